// File: rtl/seg7_scan_ctrl_if.sv
// Signal bundle between application logic and the 7-segment scan controller.
// The application side (master) drives digit data and controls; the controller (slave) drives the pins.
interface seg7_scan_ctrl_if #(
  parameter int NUM_DIGITS  = 8,
  parameter int BRIGHT_BITS = 4
);
  logic [4*NUM_DIGITS-1:0] x;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    lz_blank;
  logic [BRIGHT_BITS-1:0]  brightness;
  logic                    load;
  logic [6:0]              a_to_g;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;

  modport master (
    output x, dp_in, digit_en, lz_blank, brightness, load,
    input  a_to_g, dp, an
  );

  modport slave (
    input  x, dp_in, digit_en, lz_blank, brightness, load,
    output a_to_g, dp, an
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment driver: shadow-loaded hex digits, per-digit
// enables and decimal points, leading-zero blanking and PWM brightness.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int CLK_DIV_BITS = 17,
  parameter int BRIGHT_BITS  = 4
) (
  input  logic            clk,
  input  logic            clr,
  seg7_scan_ctrl_if.slave bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  // Active-low gfedcba patterns for hex digits 0..F.
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  logic [CLK_DIV_BITS-1:0] presc_p0;
  logic [IDX_W-1:0]        idx_p0;
  logic [4*NUM_DIGITS-1:0] x_p0;
  logic [NUM_DIGITS-1:0]   dp_p0;
  logic [NUM_DIGITS-1:0]   en_p0;

  logic [NUM_DIGITS-1:0]   an_p1;
  logic [6:0]              seg_p1;
  logic                    dpo_p1;

  logic [3:0] nib_cur;
  logic       dp_cur;
  logic       en_cur;
  logic       nz_at_or_above;
  logic       suppress;
  logic       pwm_on;
  logic       lit;

  // Stage p0: prescaler, scan index and shadow registers
  always_ff @(posedge clk) begin
    if (clr) begin
      presc_p0 <= '0;
      idx_p0   <= '0;
      x_p0     <= '0;
      dp_p0    <= '0;
      en_p0    <= '0;
    end else begin
      presc_p0 <= presc_p0 + 1'b1;
      if (&presc_p0)
        idx_p0 <= (idx_p0 == LAST_IDX) ? '0 : idx_p0 + 1'b1;
      if (bus.load) begin
        x_p0  <= bus.x;
        dp_p0 <= bus.dp_in;
        en_p0 <= bus.digit_en;
      end
    end
  end

  always_comb begin
    nib_cur        = 4'h0;
    dp_cur         = 1'b0;
    en_cur         = 1'b0;
    nz_at_or_above = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IDX_W'(i) == idx_p0) begin
        nib_cur = x_p0[4*i +: 4];
        dp_cur  = dp_p0[i];
        en_cur  = en_p0[i];
      end
      // Any non-zero nibble at or above the current digit ends the leading-zero run.
      if (IDX_W'(i) >= idx_p0 && x_p0[4*i +: 4] != 4'h0)
        nz_at_or_above = 1'b1;
    end
    suppress = bus.lz_blank && (idx_p0 != '0) && !dp_cur && !nz_at_or_above;
    pwm_on   = (presc_p0[CLK_DIV_BITS-1 -: BRIGHT_BITS] < bus.brightness) || (&bus.brightness);
    lit      = en_cur && !suppress && pwm_on;
  end

  // Stage p1: registered pin drivers, all switching on the same edge
  always_ff @(posedge clk) begin
    if (clr || !lit) begin
      an_p1  <= '1;
      seg_p1 <= 7'b1111111;
      dpo_p1 <= 1'b1;
    end else begin
      an_p1  <= ~(NUM_DIGITS'(1) << idx_p0);
      seg_p1 <= hex_decode(nib_cur);
      dpo_p1 <= ~dp_cur;
    end
  end

  assign bus.an     = an_p1;
  assign bus.a_to_g = seg_p1;
  assign bus.dp     = dpo_p1;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: directed scenarios plus random traffic, all outputs checked
// every cycle against a time-counter based reference model.
module tb_seg7_scan_ctrl;

  localparam int ND   = 3;
  localparam int CDB  = 4;
  localparam int BB   = 2;
  localparam int XW   = 4*ND;
  localparam int SLOT = 1 << CDB;
  localparam int BMAX = (1 << BB) - 1;

  logic clk = 1'b0;
  logic clr;

  seg7_scan_ctrl_if #(.NUM_DIGITS(ND), .BRIGHT_BITS(BB)) bus ();

  seg7_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .CLK_DIV_BITS(CDB),
    .BRIGHT_BITS (BB)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [6:0] SEG_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: k counts edges since reset; prescaler and index follow from it.
  int         k = 0;
  logic [3:0] sh_x  [ND];
  logic       sh_dp [ND];
  logic       sh_en [ND];
  logic [ND-1:0] e_an;
  logic [6:0]    e_seg;
  logic          e_dp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    int d;
    int pr;
    bit on;
    bit zabove;
    bit sup;
    @(posedge clk);
    if (clr) begin
      e_an = '1; e_seg = 7'h7F; e_dp = 1'b1; k = 0;
      for (int i = 0; i < ND; i++) begin
        sh_x[i] = 4'h0; sh_dp[i] = 1'b0; sh_en[i] = 1'b0;
      end
    end else begin
      d  = (k / SLOT) % ND;
      pr = k % SLOT;
      on = ((pr >> (CDB - BB)) < int'(bus.brightness)) || (int'(bus.brightness) == BMAX);
      zabove = 1'b1;
      for (int j = d; j < ND; j++)
        if (sh_x[j] != 4'h0) zabove = 1'b0;
      sup = bus.lz_blank && (d != 0) && !sh_dp[d] && zabove;
      if (sh_en[d] && !sup && on) begin
        e_an = '1; e_an[d] = 1'b0; e_seg = SEG_TAB[sh_x[d]]; e_dp = ~sh_dp[d];
      end else begin
        e_an = '1; e_seg = 7'h7F; e_dp = 1'b1;
      end
      k++;
      if (bus.load)
        for (int i = 0; i < ND; i++) begin
          sh_x[i] = bus.x[4*i +: 4]; sh_dp[i] = bus.dp_in[i]; sh_en[i] = bus.digit_en[i];
        end
    end
    #1;
    chk("model_an", 32'(bus.an), 32'(e_an));
    chk("model_seg", 32'(bus.a_to_g), 32'(e_seg));
    chk("model_dp", 32'(bus.dp), 32'(e_dp));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rand_inputs();
    bus.x          = XW'($urandom);
    bus.dp_in      = ND'($urandom);
    bus.digit_en   = ND'($urandom);
    bus.lz_blank   = 1'($urandom);
    bus.brightness = BB'($urandom);
    bus.load       = 1'($urandom);
  endtask

  task automatic set_digits(input logic [XW-1:0] xv, input logic [ND-1:0] dpv,
                            input logic [ND-1:0] env, input logic lz, input logic [BB-1:0] br);
    bus.x = xv; bus.dp_in = dpv; bus.digit_en = env; bus.lz_blank = lz; bus.brightness = br;
  endtask

  initial begin
    bit seen0, seen_hi, bad_seg, seen_f;
    int lit_cnt;

    // Reset with arbitrary inputs
    clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      step();
      chk("rst_an", 32'(bus.an), 32'h7);
      chk("rst_seg", 32'(bus.a_to_g), 32'h7F);
      chk("rst_dp", 32'(bus.dp), 32'h1);
    end

    // Scan and wrap
    clr = 1'b0;
    set_digits(12'h5A3, 3'b000, 3'b111, 1'b0, 2'b11);
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    step();
    chk("scan_d0_an", 32'(bus.an), 32'b110);
    chk("scan_d0_seg", 32'(bus.a_to_g), 32'b0110000);
    run(16);
    chk("scan_d1_an", 32'(bus.an), 32'b101);
    chk("scan_d1_seg", 32'(bus.a_to_g), 32'b0001000);
    run(16);
    chk("scan_d2_an", 32'(bus.an), 32'b011);
    chk("scan_d2_seg", 32'(bus.a_to_g), 32'b0010010);
    run(16);
    chk("scan_wrap_an", 32'(bus.an), 32'b110);

    // Leading-zero blanking
    set_digits(12'h007, 3'b000, 3'b111, 1'b1, 2'b11);
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    seen0 = 0; seen_hi = 0; bad_seg = 0;
    for (int i = 0; i < 48; i++) begin
      step();
      if (bus.an[0] == 1'b0) begin
        seen0 = 1;
        if (bus.a_to_g != 7'b1111000) bad_seg = 1;
      end
      if (bus.an[2:1] != 2'b11) seen_hi = 1;
    end
    chk("lzb_d0_seen", 32'(seen0), 32'd1);
    chk("lzb_hi_dark", 32'(seen_hi), 32'd0);
    chk("lzb_d0_seg", 32'(bad_seg), 32'd0);

    bus.lz_blank = 1'b0;
    seen_hi = 0; bad_seg = 0;
    for (int i = 0; i < 48; i++) begin
      step();
      if (bus.an[2:1] != 2'b11) begin
        seen_hi = 1;
        if (bus.a_to_g != 7'b1000000) bad_seg = 1;
      end
    end
    chk("nolzb_hi_seen", 32'(seen_hi), 32'd1);
    chk("nolzb_hi_seg", 32'(bad_seg), 32'd0);

    // Decimal point overrides blanking
    set_digits(12'h000, 3'b010, 3'b111, 1'b1, 2'b11);
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    seen0 = 0; seen_hi = 0; bad_seg = 0;
    for (int i = 0; i < 48; i++) begin
      step();
      if (bus.an[1] == 1'b0) begin
        seen0 = 1;
        if (bus.a_to_g != 7'b1000000 || bus.dp != 1'b0) bad_seg = 1;
      end
      if (bus.an[2] == 1'b0) seen_hi = 1;
    end
    chk("dp_d1_seen", 32'(seen0), 32'd1);
    chk("dp_d1_seg", 32'(bad_seg), 32'd0);
    chk("dp_d2_dark", 32'(seen_hi), 32'd0);

    // Brightness
    set_digits(12'h5A3, 3'b000, 3'b111, 1'b0, 2'b01);
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    step();
    lit_cnt = 0;
    for (int i = 0; i < 48; i++) begin
      step();
      if (bus.an != 3'b111) lit_cnt++;
    end
    chk("bri1_lit_cycles", 32'(lit_cnt), 32'd12);
    bus.brightness = 2'b00;
    lit_cnt = 0;
    for (int i = 0; i < 48; i++) begin
      step();
      if (bus.an != 3'b111) lit_cnt++;
    end
    chk("bri0_lit_cycles", 32'(lit_cnt), 32'd0);

    // Shadow is tear-free: live x ignored until load
    bus.brightness = 2'b11;
    bus.x = 12'hFFF;
    seen_f = 0;
    for (int i = 0; i < 48; i++) begin
      step();
      if (bus.a_to_g == 7'b0001110) seen_f = 1;
    end
    chk("shadow_hold", 32'(seen_f), 32'd0);
    bus.x = 12'h888;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    chk("load_edge_old", 32'(bus.a_to_g != 7'b0000000), 32'd1);
    step();
    chk("load_next_new", 32'(bus.a_to_g), 32'b0000000);

    // Reset mid-slot
    run(5);
    clr = 1'b1;
    step();
    chk("midrst_an", 32'(bus.an), 32'h7);
    chk("midrst_seg", 32'(bus.a_to_g), 32'h7F);
    clr = 1'b0;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    chk("midrst_shadow_clr", 32'(bus.an), 32'h7);
    step();
    chk("midrst_idx0", 32'(bus.an), 32'b110);
    run(15);
    chk("midrst_idx1", 32'(bus.an), 32'b101);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      clr = ($urandom_range(0, 59) == 0);
      step();
    end
    clr = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
